// File: rtl/uart_tx_feeder.sv
// ---------------------------------------------------------------------------
// uart_tx_feeder
//
// Byte FIFO and issue controller placed directly in front of the UART
// transmitter. Bytes written from the system side are buffered and handed
// to the transmitter one at a time as a single-cycle strobe on
// TX_DATA_VALID with the byte on TX_P_DATA. Issue is paced by TX_BUSY so
// that no byte is offered while a frame is still being shifted out. A
// bounded wait for TX_BUSY to rise keeps the controller from hanging if the
// transmitter never acknowledges a strobe.
//
// Ports:
//   CLK            in   1            TX clock
//   RST            in   1            asynchronous active-low reset
//   WR_DATA        in   DATA_WIDTH   byte to enqueue
//   WR_EN          in   1            enqueue request, sampled every rising edge
//   FULL           out  1            FIFO holds DEPTH bytes
//   EMPTY          out  1            FIFO holds no bytes
//   COUNT          out  ADDR_WIDTH+1 number of bytes stored
//   OVERFLOW       out  1            sticky: a write was attempted while FULL
//   TX_P_DATA      out  DATA_WIDTH   byte presented to the transmitter
//   TX_DATA_VALID  out  1            one-cycle issue strobe to the transmitter
//   TX_BUSY        in   1            transmitter busy indication
// ---------------------------------------------------------------------------
module uart_tx_feeder #(
    parameter int DATA_WIDTH   = 8,
    parameter int DEPTH        = 8,
    parameter int ADDR_WIDTH   = 3,
    parameter int BUSY_TIMEOUT = 7
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] WR_DATA,
    input  logic                  WR_EN,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic [ADDR_WIDTH:0]   COUNT,
    output logic                  OVERFLOW,
    output logic [DATA_WIDTH-1:0] TX_P_DATA,
    output logic                  TX_DATA_VALID,
    input  logic                  TX_BUSY
);

    // -----------------------------------------------------------------------
    // Constants
    // -----------------------------------------------------------------------
    localparam logic [ADDR_WIDTH:0]   CNT_FULL  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_ZERO  = (ADDR_WIDTH+1)'(0);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ZERO  = ADDR_WIDTH'(0);
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = DATA_WIDTH'(0);
    localparam logic [3:0]            TMO_LVL   = 4'(BUSY_TIMEOUT);
    localparam logic [3:0]            TMO_ZERO  = 4'd0;
    localparam logic [3:0]            TMO_ONE   = 4'd1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT_HI = 2'd2,
        S_WAIT_LO = 2'd3
    } state_e;

    // -----------------------------------------------------------------------
    // Storage and state
    // -----------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    state_e                state_q,     state_d;
    logic [3:0]            tmo_cnt_q,   tmo_cnt_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q,    wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q,    rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q,     count_d;
    logic                  full_q,      full_d;
    logic                  empty_q,     empty_d;
    logic                  overflow_q,  overflow_d;
    logic [DATA_WIDTH-1:0] tx_data_q,   tx_data_d;
    logic                  tx_valid_q,  tx_valid_d;

    logic                  wr_accept_s;
    logic                  pop_s;
    logic [3:0]            tmo_inc_s;

    // Write admission uses the registered FULL flag only, so a pop on the
    // same edge never makes room for a write that arrived while full.
    assign wr_accept_s = WR_EN & ~full_q;
    assign tmo_inc_s   = tmo_cnt_q + TMO_ONE;

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    // Holds the issue-controller state.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    // Decides when to issue and how long to wait for the transmitter.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!empty_q && !TX_BUSY) begin
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                // A strobe the transmitter never acknowledges is dropped
                // after the timeout rather than re-sent.
                if (TX_BUSY) begin
                    state_d = S_WAIT_LO;
                end else if (tmo_inc_s == TMO_LVL) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT_HI;
                end
            end
            S_WAIT_LO: begin
                if (!TX_BUSY) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT_LO;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: output logic
    // -----------------------------------------------------------------------
    // Produces the next values of the registered strobe, data and timeout
    // counter, plus the pop request for the FIFO.
    always_comb begin
        tmo_cnt_d  = tmo_cnt_q;
        pop_s      = 1'b0;
        tx_valid_d = 1'b0;
        tx_data_d  = tx_data_q;

        // Strobe and data are loaded on the edge entering ISSUE so both are
        // valid for the whole ISSUE cycle. The slot at rd_ptr is guaranteed
        // to be written because ISSUE is only entered when not empty.
        if (state_d == S_ISSUE) begin
            tx_valid_d = 1'b1;
            tx_data_d  = mem_q[rd_ptr_q];
        end else begin
            tx_valid_d = 1'b0;
            tx_data_d  = tx_data_q;
        end

        case (state_q)
            S_IDLE: begin
                tmo_cnt_d = tmo_cnt_q;
            end
            S_ISSUE: begin
                // The byte leaves the FIFO on the edge exiting ISSUE.
                pop_s     = 1'b1;
                tmo_cnt_d = TMO_ZERO;
            end
            S_WAIT_HI: begin
                if (!TX_BUSY) begin
                    tmo_cnt_d = tmo_inc_s;
                end else begin
                    tmo_cnt_d = tmo_cnt_q;
                end
            end
            S_WAIT_LO: begin
                tmo_cnt_d = tmo_cnt_q;
            end
            default: begin
                tmo_cnt_d = TMO_ZERO;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FIFO bookkeeping
    // -----------------------------------------------------------------------
    // Computes pointer, occupancy and flag updates from write/pop requests.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (wr_accept_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({wr_accept_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        if (WR_EN && full_q) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_q;
        end

        full_d  = (count_d == CNT_FULL);
        empty_d = (count_d == CNT_ZERO);
    end

    // Registers pointers, occupancy and status flags.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr_q   <= PTR_ZERO;
            rd_ptr_q   <= PTR_ZERO;
            count_q    <= CNT_ZERO;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
        end
    end

    // Stores accepted bytes; contents are intentionally left unreset.
    always_ff @(posedge CLK) begin
        if (wr_accept_s) begin
            mem_q[wr_ptr_q] <= WR_DATA;
        end
    end

    // Registers the transmitter-facing outputs and the timeout counter.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tx_data_q  <= DATA_ZERO;
            tx_valid_q <= 1'b0;
            tmo_cnt_q  <= TMO_ZERO;
        end else begin
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            tmo_cnt_q  <= tmo_cnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign FULL          = full_q;
    assign EMPTY         = empty_q;
    assign COUNT         = count_q;
    assign OVERFLOW      = overflow_q;
    assign TX_P_DATA     = tx_data_q;
    assign TX_DATA_VALID = tx_valid_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_feeder
//
// Self-checking bench for uart_tx_feeder. Bytes that should reach the
// transmitter are pushed to a scoreboard when written; a monitor pops and
// compares them whenever TX_DATA_VALID strobes. A simple transmitter model
// raises TX_BUSY for a programmable number of cycles after each strobe.
// ---------------------------------------------------------------------------
module tb_uart_tx_feeder;

    localparam int DW  = 8;
    localparam int DEP = 8;
    localparam int AW  = 3;
    localparam int TMO = 7;

    logic          CLK = 1'b0;
    logic          RST;
    logic [DW-1:0] WR_DATA;
    logic          WR_EN;
    logic          FULL;
    logic          EMPTY;
    logic [AW:0]   COUNT;
    logic          OVERFLOW;
    logic [DW-1:0] TX_P_DATA;
    logic          TX_DATA_VALID;
    logic          TX_BUSY;

    int         n_checks   = 0;
    int         n_fail     = 0;
    logic [7:0] sb[$];
    int         cyc        = 0;
    int         strobe_cyc[$];
    int         n_strobes  = 0;
    logic       prev_valid = 1'b0;
    int         busy_len   = 3;
    bit         hold_busy  = 1'b0;
    int         busy_cnt   = 0;

    uart_tx_feeder #(
        .DATA_WIDTH   (DW),
        .DEPTH        (DEP),
        .ADDR_WIDTH   (AW),
        .BUSY_TIMEOUT (TMO)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .WR_DATA       (WR_DATA),
        .WR_EN         (WR_EN),
        .FULL          (FULL),
        .EMPTY         (EMPTY),
        .COUNT         (COUNT),
        .OVERFLOW      (OVERFLOW),
        .TX_P_DATA     (TX_P_DATA),
        .TX_DATA_VALID (TX_DATA_VALID),
        .TX_BUSY       (TX_BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Drive one write at the current negedge; returns one cycle later.
    task automatic wr_byte(input logic [7:0] d, input bit accepted);
        WR_DATA = d;
        WR_EN   = 1'b1;
        if (accepted) sb.push_back(d);
        @(negedge CLK);
        WR_EN   = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int max_cyc, input int settle);
        int n = 0;
        while (sb.size() != 0 && n < max_cyc) begin
            @(negedge CLK);
            n++;
        end
        check_eq(tag, 32'(sb.size()), 32'd0);
        repeat (settle) @(negedge CLK);
    endtask

    task automatic wait_strobe(input string tag, input int max_cyc);
        int n = 0;
        while (TX_DATA_VALID !== 1'b1 && n < max_cyc) begin
            @(negedge CLK);
            n++;
        end
        check_eq(tag, 32'(TX_DATA_VALID), 32'd1);
    endtask

    // Transmitter model: busy for busy_len cycles after each strobe.
    initial begin
        TX_BUSY = 1'b0;
        forever begin
            @(negedge CLK);
            if (busy_cnt > 0) busy_cnt--;
            if (TX_DATA_VALID === 1'b1 && busy_len > 0) busy_cnt = busy_len;
            TX_BUSY = hold_busy || (busy_cnt > 0);
        end
    end

    // Monitor: scoreboard compare, strobe spacing and occupancy bound.
    initial begin
        forever begin
            @(negedge CLK);
            cyc++;
            check_eq("count_le_depth", 32'(COUNT <= 4'd8), 32'd1);
            if (TX_DATA_VALID === 1'b1) begin
                check_eq("strobe_gap", 32'(prev_valid), 32'd0);
                check_eq("strobe_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) check_eq("tx_data", 32'(TX_P_DATA), 32'(sb.pop_front()));
                n_strobes++;
                strobe_cyc.push_back(cyc);
            end
            prev_valid = TX_DATA_VALID;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s0;
        RST     = 1'b0;
        WR_EN   = 1'b0;
        WR_DATA = 8'h00;
        repeat (2) @(negedge CLK);
        check_eq("rst_count",    32'(COUNT),         32'd0);
        check_eq("rst_empty",    32'(EMPTY),         32'd1);
        check_eq("rst_full",     32'(FULL),          32'd0);
        check_eq("rst_overflow", 32'(OVERFLOW),      32'd0);
        check_eq("rst_valid",    32'(TX_DATA_VALID), 32'd0);
        check_eq("rst_data",     32'(TX_P_DATA),     32'd0);
        RST = 1'b1;
        @(negedge CLK);

        // Single byte: strobe two edges after the write edge.
        busy_len = 100;
        wr_byte(8'hA5, 1'b1);
        check_eq("single_k_valid", 32'(TX_DATA_VALID), 32'd0);
        check_eq("single_k_count", 32'(COUNT),         32'd1);
        check_eq("single_k_empty", 32'(EMPTY),         32'd0);
        @(negedge CLK);
        check_eq("single_k1_valid", 32'(TX_DATA_VALID), 32'd1);
        check_eq("single_k1_data",  32'(TX_P_DATA),     32'hA5);
        @(negedge CLK);
        check_eq("single_k2_valid", 32'(TX_DATA_VALID), 32'd0);
        check_eq("single_k2_count", 32'(COUNT),         32'd0);
        check_eq("single_k2_empty", 32'(EMPTY),         32'd1);
        check_eq("single_data_hold", 32'(TX_P_DATA),    32'hA5);
        repeat (115) @(negedge CLK);
        check_eq("single_strobes", 32'(n_strobes), 32'd1);

        // Burst fill to FULL, overflow, then drain in order.
        busy_len  = 3;
        hold_busy = 1'b1;
        repeat (2) @(negedge CLK);
        for (int i = 1; i <= 8; i++) wr_byte(8'(i), 1'b1);
        check_eq("burst_full",  32'(FULL),  32'd1);
        check_eq("burst_count", 32'(COUNT), 32'd8);
        wr_byte(8'hFF, 1'b0);
        check_eq("burst_overflow",   32'(OVERFLOW), 32'd1);
        check_eq("burst_count_ovf",  32'(COUNT),    32'd8);
        hold_busy = 1'b0;
        wait_drain("burst_drain", 300, 15);
        check_eq("burst_empty", 32'(EMPTY), 32'd1);
        check_eq("burst_strobes", 32'(n_strobes), 32'd9);

        // Wrap-around with intermittent draining.
        for (int i = 0; i < 20; i++) begin
            wr_byte(8'(8'h20 + i), 1'b1);
            if (i % 3 == 2) wait_drain("wrap_drain_part", 100, 0);
        end
        wait_drain("wrap_drain", 200, 15);
        check_eq("wrap_empty", 32'(EMPTY), 32'd1);

        // Simultaneous write and pop at COUNT=4.
        hold_busy = 1'b1;
        repeat (2) @(negedge CLK);
        for (int i = 0; i < 4; i++) wr_byte(8'(8'h40 + i), 1'b1);
        check_eq("simul_count_init", 32'(COUNT), 32'd4);
        hold_busy = 1'b0;
        wait_strobe("simul_strobe_seen", 20);
        check_eq("simul_count_pre", 32'(COUNT), 32'd4);
        wr_byte(8'h44, 1'b1);
        check_eq("simul_count_post", 32'(COUNT), 32'd4);
        wait_drain("simul_drain", 200, 15);

        // Busy timeout: transmitter never acknowledges.
        busy_len = 0;
        strobe_cyc.delete();
        wr_byte(8'hC3, 1'b1);
        wr_byte(8'h3C, 1'b1);
        wait_drain("tmo_drain", 100, 15);
        check_eq("tmo_strobes", 32'(strobe_cyc.size()), 32'd2);
        if (strobe_cyc.size() == 2) begin
            check_eq("tmo_gap_min", 32'((strobe_cyc[1] - strobe_cyc[0]) >= TMO + 2), 32'd1);
            check_eq("tmo_gap_max", 32'((strobe_cyc[1] - strobe_cyc[0]) <= TMO + 3), 32'd1);
        end
        check_eq("tmo_empty", 32'(EMPTY), 32'd1);

        // Asynchronous reset while in WAIT_LO with three bytes queued.
        busy_len  = 30;
        hold_busy = 1'b1;
        repeat (2) @(negedge CLK);
        for (int i = 0; i < 4; i++) wr_byte(8'(8'h50 + i), 1'b1);
        check_eq("ovf_sticky", 32'(OVERFLOW), 32'd1);
        hold_busy = 1'b0;
        wait_strobe("rst_strobe_seen", 20);
        repeat (3) @(negedge CLK);
        check_eq("pre_rst_count", 32'(COUNT), 32'd3);
        #2;
        RST = 1'b0;
        #1;
        check_eq("arst_count",    32'(COUNT),         32'd0);
        check_eq("arst_empty",    32'(EMPTY),         32'd1);
        check_eq("arst_full",     32'(FULL),          32'd0);
        check_eq("arst_valid",    32'(TX_DATA_VALID), 32'd0);
        check_eq("arst_overflow", 32'(OVERFLOW),      32'd0);
        check_eq("arst_data",     32'(TX_P_DATA),     32'd0);
        sb.delete();
        s0 = n_strobes;
        @(negedge CLK);
        RST = 1'b1;
        repeat (40) @(negedge CLK);
        check_eq("post_rst_no_strobe", 32'(n_strobes), 32'(s0));
        check_eq("post_rst_empty",     32'(EMPTY),     32'd1);
        busy_len = 3;
        wr_byte(8'h5A, 1'b1);
        wait_drain("post_rst_drain", 50, 10);
        check_eq("post_rst_strobe", 32'(n_strobes), 32'(s0 + 1));

        check_eq("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
